// File: rtl/bram_axis_streamer.sv
// Frame source: reads fixed-length frames from a single-port BRAM and
// streams them as an AXI4-Stream master behind a 2-entry credit FIFO.
module bram_axis_streamer #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int FRAME_LEN  = 786
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [7:0]            num_frames,
    input  logic                  stop,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic [7:0]            frame_cnt;
    logic [7:0]            frames;
    logic                  stop_lat;
    logic                  inflight;
    logic                  inf_first;
    logic                  inf_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_first;
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  hs;
    logic                  issue;
    logic                  beat_last;
    logic                  final_rd;
    logic                  done_nxt;

    assign m_axis_tvalid = (count != 2'd0);
    assign hs            = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid & fifo_last[rd_ptr];
    assign m_axis_tuser  = m_axis_tvalid & fifo_first[rd_ptr];
    assign busy          = (state != IDLE);
    assign bram_en       = issue;
    assign bram_addr     = BASE + beat_cnt;

    // Entries already committed: buffered beats plus the read in flight
    assign occ       = {1'b0, count} + {2'b00, inflight};
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign final_rd  = beat_last &&
                       (((frames != 8'd0) && (frame_cnt == frames - 8'd1)) ||
                        stop_lat || stop);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                issue = (occ < (3'd2 + {2'b00, hs}));
                if (issue && final_rd) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!inflight && (count == 2'd1) && hs) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            done      <= 1'b0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            frames    <= '0;
            stop_lat  <= 1'b0;
            inflight  <= 1'b0;
            inf_first <= 1'b0;
            inf_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            inflight <= issue;
            if (state == IDLE) begin
                if (start) begin
                    frames    <= num_frames;
                    beat_cnt  <= '0;
                    frame_cnt <= '0;
                    stop_lat  <= 1'b0;
                end
            end else if (stop) begin
                stop_lat <= 1'b1;
            end
            if (issue) begin
                inf_first <= (beat_cnt == '0);
                inf_last  <= beat_last;
                if (beat_last) begin
                    beat_cnt  <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            fifo_first <= 2'b00;
            fifo_last  <= 2'b00;
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr]  <= bram_dout;
                fifo_first[wr_ptr] <= inf_first;
                fifo_last[wr_ptr]  <= inf_last;
                wr_ptr             <= ~wr_ptr;
            end
            if (hs) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, hs};
        end
    end

endmodule

// File: tb/tb_bram_axis_streamer.sv
// Scoreboard bench: frames are expanded into an expected beat queue at
// start time; a negedge monitor pops and compares every handshake.
module tb_bram_axis_streamer;

    localparam int DW   = 20;
    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int FL   = 786;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_frames = 8'd0;
    logic          stop = 1'b0;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tlast;
    logic          tuser;
    logic          busy;
    logic          done;

    bram_axis_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_LEN(FL)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .num_frames(num_frames), .stop(stop),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast),
        .m_axis_tuser(tuser), .busy(busy), .done(done)
    );

    always #5 aclk = ~aclk;

    logic [DW-1:0] mem [1<<AW];
    always @(posedge aclk) if (bram_en) bram_dout <= mem[bram_addr];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } beat_t;

    beat_t expq[$];
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int issued = 0;
    int taken = 0;
    bit rand_bp = 1'b0;
    bit pending_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic prev_l, prev_u;
    logic hs;
    beat_t e;

    always @(posedge aclk) begin
        #1;
        tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: all DUT outputs sampled on the falling edge
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall   = 1'b0;
            pending_done = 1'b0;
            issued       = 0;
            taken        = 0;
        end else begin
            hs = tvalid && tready;
            if (pending_done) begin
                chk("done_after_tlast", {30'd0, done, busy}, 32'h2);
                pending_done = 1'b0;
            end else if (done) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end
            if (prev_stall)
                chk("stall_hold", {tvalid, tlast, tuser, 9'd0, tdata},
                    {1'b1, prev_l, prev_u, 9'd0, prev_d});
            if (bram_en)
                chk("read_credit",
                    32'(busy && ((issued - taken - (hs ? 1 : 0)) < 2)), 32'h1);
            if (hs) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 32'(tdata), 32'hFFFFFFFF);
                end else begin
                    e = expq.pop_front();
                    chk("beat", {10'd0, tuser, tlast, tdata},
                        {10'd0, e.f, e.l, e.d});
                    if (e.l && expq.size() == 0) pending_done = 1'b1;
                end
                beats_seen++;
            end
            issued += bram_en ? 1 : 0;
            taken  += hs ? 1 : 0;
            prev_stall = tvalid && !tready;
            prev_d = tdata;
            prev_l = tlast;
            prev_u = tuser;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int b = 0; b < FL; b++)
                expq.push_back({mem[BASE + b], b == 0, b == FL - 1});
    endtask

    task automatic do_start(input logic [7:0] nf);
        beats_seen = 0;
        num_frames = nf;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_frames = 8'($urandom);
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("lat_e0", 32'(tvalid), 32'h0);
        tick();
        chk("lat_e1", 32'(tvalid), 32'h0);
        tick();
        chk("lat_e2", 32'(tvalid), 32'h1);
    endtask

    task automatic wait_done(input int budget, inout int cyc);
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", 32'(cyc), 32'(budget + 1));
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beats_seen < n && t < 20 * n) begin
            tick();
            t++;
        end
        chk("reach_beat", 32'(beats_seen >= n), 32'h1);
    endtask

    task automatic settle();
        repeat (4) tick();
        chk("queue_empty", 32'(expq.size()), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

        repeat (3) tick();
        chk("rst_out", {tvalid, tlast, tuser, busy, done, bram_en, 6'd0, tdata},
            32'h0);
        chk("rst_addr", 32'(bram_addr), 32'(BASE));
        areset = 1'b0;
        repeat (2) tick();

        // single frame, full throughput
        push_frames(1);
        do_start(8'd1);
        cyc = 2;
        wait_done(4 * FL, cyc);
        chk("single_cycles", 32'(cyc), 32'(FL + 2));
        settle();

        // random backpressure
        rand_bp = 1'b1;
        push_frames(1);
        do_start(8'd1);
        cyc = 2;
        wait_done(8 * FL, cyc);
        rand_bp = 1'b0;
        chk("bp_beats", 32'(beats_seen), 32'(FL));
        settle();

        // three frames back to back
        push_frames(3);
        do_start(8'd3);
        cyc = 2;
        wait_done(12 * FL, cyc);
        chk("multi_cycles", 32'(cyc), 32'(3 * FL + 2));
        settle();

        // continuous mode ended by a stop pulse at beat 1000
        push_frames(1000 / FL + 1);
        do_start(8'd0);
        wait_beats(1000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cyc = 0;
        wait_done(8 * FL, cyc);
        chk("stop_beats", 32'(beats_seen), 32'(2 * FL));
        repeat (20) tick();
        settle();

        // stop while idle is ignored; start while running is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push_frames(2);
        do_start(8'd2);
        cyc = 2;
        repeat (100) begin
            tick();
            cyc++;
        end
        num_frames = 8'd7;
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        wait_done(8 * FL, cyc);
        chk("ignored_start_cycles", 32'(cyc), 32'(2 * FL + 2));
        settle();

        // reset in the middle of a frame
        push_frames(1);
        do_start(8'd1);
        wait_beats(400);
        areset = 1'b1;
        #1;
        chk("midrst_out",
            {tvalid, tlast, tuser, busy, done, bram_en, 6'd0, tdata}, 32'h0);
        chk("midrst_addr", 32'(bram_addr), 32'(BASE));
        expq.delete();
        tick();
        tick();
        areset = 1'b0;
        tick();
        push_frames(1);
        do_start(8'd1);
        cyc = 2;
        wait_done(4 * FL, cyc);
        chk("restart_cycles", 32'(cyc), 32'(FL + 2));
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_axis_streamer.md
# bram_axis_streamer

Parametrised frame source that reads fixed-length frames from a synchronous single-port BRAM and emits them as an AXI4-Stream master with full `tready` backpressure, per-frame `tlast`/`tuser` and finite or continuous frame repetition. It sits between the image/weight BRAM and the stream input of the IODMA processing core. It replaces free-running, `tready`-blind address counters with a credit-controlled read pipeline that never drops or duplicates a beat.

## Interface
- `DATA_WIDTH`, 20: BRAM word and `m_axis_tdata` width.
- `ADDR_WIDTH`, 10: BRAM address width.
- `BASE_ADDR`, 0: address of the first word of a frame.
- `FRAME_LEN`, 786: beats per frame (28*28 pixels + 2 header words); 1 ≤ FRAME_LEN ≤ 2^ADDR_WIDTH − BASE_ADDR.
- `aclk`  in  1  clock, all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `num_frames`  in  8  frames to send, sampled with `start`; 0 means continuous until `stop`.
- `stop`  in  1  request to end after the current frame; level or pulse, latched.
- `bram_en`  out  1  BRAM read enable.
- `bram_addr`  out  ADDR_WIDTH  BRAM read address.
- `bram_dout`  in  DATA_WIDTH  BRAM read data, valid one cycle after `bram_en`.
- `m_axis_tdata`  out  DATA_WIDTH  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last beat of each frame.
- `m_axis_tuser`  out  1  first beat of each frame.
- `busy`  out  1  high from the `start` edge until `done`.
- `done`  out  1  one-cycle pulse when the final beat has handshaked.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 latches `num_frames`, clears `beat_cnt`/`frame_cnt`/stop latch, sets `busy`, goes to RUN.
- RUN issues reads. A read is issued in a cycle (`bram_en`=1, `bram_addr`=BASE_ADDR+`beat_cnt`) iff `fifo_count + inflight − (tvalid & tready) < 2`.
- Output FIFO depth is 2. `inflight` is 0 or 1. Each entry carries data plus first and last tag bits computed at issue.
- `beat_cnt` wraps to 0 after FRAME_LEN−1 and increments `frame_cnt`.
- Final read: `beat_cnt`=FRAME_LEN−1 and either (`num_frames`≠0 and `frame_cnt`=`num_frames`−1) or the stop latch is set. After issuing it, the block goes to DRAIN.
- `stop` never truncates a frame. If it arrives during the last beat's issue cycle, it still counts.
- DRAIN issues no reads. When the FIFO is empty and `inflight`=0, the block pulses `done`, clears `busy` and goes to IDLE.
- `start` while `busy` is ignored. `stop` in IDLE is ignored.
- `m_axis_tdata`/`tlast`/`tuser` come from the FIFO head. They hold stable while `tvalid`=1 and `tready`=0.
- `tvalid` never drops without a handshake.
- `areset` mid-frame: all state cleared immediately, in-flight read discarded, no partial `tlast` emitted.

## Timing
- Reset values:
  - `bram_en`=0, `bram_addr`=BASE_ADDR.
  - `m_axis_tvalid`/`tlast`/`tuser`=0, `m_axis_tdata`=0.
  - `busy`=0, `done`=0, FIFO empty, state IDLE.
- `start` sampled at edge E0 → first `bram_en` in the cycle after E0 → data written into the FIFO at E2 → `m_axis_tvalid`=1 after E2. Latency is 2 cycles.
- With `tready` held at 1, throughput is 1 beat/cycle. A frame occupies exactly FRAME_LEN consecutive valid cycles. Consecutive frames have no gap.
- `tready` low for k cycles: at most 2 beats buffered, reads stall within 1 cycle, no loss or duplication. Streaming resumes 1 beat/cycle on the first cycle `tready` returns.
- `done` is asserted in the cycle after the final handshake (`tlast` of the last frame). `busy` falls on the same edge.
- A new `start` is accepted on the edge after `done`.

## Test plan
- Single frame: `num_frames`=1, BRAM[a]=a, `tready`=1 → 786 beats with data 0..785 on consecutive cycles; `tuser` on beat 0, `tlast` on beat 785; `done` 1 cycle later; first valid 2 cycles after `start`.
- Backpressure: `tready` random 50% → identical 786-beat sequence; data/`tlast` stable while stalled; no `bram_en` issued when FIFO count + inflight would exceed 2.
- Multi-frame: `num_frames`=3 → 2358 beats; three `tlast` at beats 785, 1571, 2357; `done` after the third.
- Continuous with stop: `num_frames`=0, `stop` pulsed at beat 1000 → stream ends at beat 1571 with `tlast`; `done` follows; no further reads.
- Reset mid-frame: assert `areset` at beat 400 for 2 cycles → all outputs 0 immediately; a subsequent `start` restarts at address BASE_ADDR with `tuser`=1.
- Ignored `start`: pulse `start` during RUN → the beat count and frame count are unchanged from the unperturbed run.
